sudoku_checker: RTL and testbench

Board-validation responder for the Sudoku controller. When the main FSM raises its check request, this block scans the 81-cell board store through a synchronous read port. It verifies row, column and 3x3-box uniqueness, flags empty cells, and returns a done pulse with a held solved/failure verdict that drives the FSM's `solved` input.

---
 rtl/sudoku_checker.sv | 201 ++++++++++++++++++++
 tb/tb_sudoku_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sudoku_checker.sv
// Board validator: streams the 81 cells of a 9x9 board through a registered read port
// and checks row/column/box uniqueness, returning a held solved/incomplete/conflict verdict.
//
// state | meaning
// IDLE  | waiting for check
// SCAN  | issuing addresses and evaluating returned cells
// DONE  | one-cycle done pulse, verdict valid
module sudoku_checker (
    input  logic       clka,
    input  logic       restart_n,
    input  logic       check,
    output logic       rd_en,
    output logic [6:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       solved,
    output logic       incomplete,
    output logic       conflict,
    output logic [6:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       eval_vld;
    logic       eval_now;
    logic       is_empty;
    logic       is_illegal;
    logic       is_dup;
    logic       cell_fail;
    logic       last_cell;
    logic [8:0] v_onehot;
    logic [8:0] seen;
    logic [6:0] eval_addr;
    logic [3:0] row_cnt;
    logic [3:0] col_cnt;
    logic [1:0] row_sub;
    logic [1:0] col_sub;
    logic [1:0] col_band;
    logic [3:0] box_base;
    logic [3:0] box_idx;
    logic [8:0] row_mask [9];
    logic [8:0] col_mask [9];
    logic [8:0] box_mask [9];

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (check) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (eval_now && (cell_fail || last_cell)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

    // Box index built from counters: base steps by 3 per row band, plus column band.
    assign box_idx  = box_base + {2'b00, col_band};
    assign eval_now = (state == SCAN) && eval_vld;

    always_comb begin
        v_onehot = '0;
        for (int i = 0; i < 9; i++) begin
            if (rd_data == 4'(i + 1)) begin
                v_onehot[i] = 1'b1;
            end
        end
    end

    assign seen       = row_mask[row_cnt] | col_mask[col_cnt] | box_mask[box_idx];
    assign is_empty   = (rd_data == 4'd0);
    assign is_illegal = (rd_data > 4'd9);
    assign is_dup     = |(seen & v_onehot);
    assign cell_fail  = is_empty || is_illegal || is_dup;
    assign last_cell  = (eval_addr == 7'd80);

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            eval_vld   <= 1'b0;
            eval_addr  <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            row_sub    <= '0;
            col_sub    <= '0;
            col_band   <= '0;
            box_base   <= '0;
            solved     <= 1'b0;
            incomplete <= 1'b0;
            conflict   <= 1'b0;
            err_addr   <= '0;
            for (int i = 0; i < 9; i++) begin
                row_mask[i] <= '0;
                col_mask[i] <= '0;
                box_mask[i] <= '0;
            end
        end else if (accept) begin
            rd_en      <= 1'b1;
            rd_addr    <= '0;
            eval_vld   <= 1'b0;
            eval_addr  <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            row_sub    <= '0;
            col_sub    <= '0;
            col_band   <= '0;
            box_base   <= '0;
            solved     <= 1'b0;
            incomplete <= 1'b0;
            conflict   <= 1'b0;
            err_addr   <= '0;
            for (int i = 0; i < 9; i++) begin
                row_mask[i] <= '0;
                col_mask[i] <= '0;
                box_mask[i] <= '0;
            end
        end else if (state == SCAN) begin
            // Data returns one cycle after the read, so the evaluate stage trails issue by one.
            eval_vld <= rd_en;
            if (rd_en) begin
                if (rd_addr == 7'd80) begin
                    rd_en <= 1'b0;
                end else begin
                    rd_addr <= rd_addr + 7'd1;
                end
            end
            if (eval_now) begin
                if (is_empty) begin
                    incomplete <= 1'b1;
                    err_addr   <= eval_addr;
                    rd_en      <= 1'b0;
                end else if (is_illegal || is_dup) begin
                    conflict <= 1'b1;
                    err_addr <= eval_addr;
                    rd_en    <= 1'b0;
                end else begin
                    row_mask[row_cnt] <= row_mask[row_cnt] | v_onehot;
                    col_mask[col_cnt] <= col_mask[col_cnt] | v_onehot;
                    box_mask[box_idx] <= box_mask[box_idx] | v_onehot;
                    solved            <= last_cell;
                    eval_addr         <= eval_addr + 7'd1;
                    if (col_cnt == 4'd8) begin
                        col_cnt  <= '0;
                        col_sub  <= '0;
                        col_band <= '0;
                        if (row_cnt == 4'd8) begin
                            row_cnt  <= '0;
                            row_sub  <= '0;
                            box_base <= '0;
                        end else begin
                            row_cnt <= row_cnt + 4'd1;
                            if (row_sub == 2'd2) begin
                                row_sub  <= '0;
                                box_base <= box_base + 4'd3;
                            end else begin
                                row_sub <= row_sub + 2'd1;
                            end
                        end
                    end else begin
                        col_cnt <= col_cnt + 4'd1;
                        if (col_sub == 2'd2) begin
                            col_sub  <= '0;
                            col_band <= col_band + 2'd1;
                        end else begin
                            col_sub <= col_sub + 2'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sudoku_checker.sv
// Scoreboard bench for sudoku_checker: a driver queues the expected verdict per check,
// a negedge monitor pops and compares whenever done pulses.
module tb_sudoku_checker;

    logic       clka = 1'b0;
    logic       restart_n = 1'b0;
    logic       check = 1'b0;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [3:0] rd_data = 4'd0;
    logic       busy;
    logic       done;
    logic       solved;
    logic       incomplete;
    logic       conflict;
    logic [6:0] err_addr;

    sudoku_checker dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .check      (check),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .solved     (solved),
        .incomplete (incomplete),
        .conflict   (conflict),
        .err_addr   (err_addr)
    );

    always #5 clka = ~clka;

    logic [3:0] mem [81];
    always @(posedge clka) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct {
        int         done_cyc;
        logic       s;
        logic       inc;
        logic       cf;
        logic [6:0] ea;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   scan_e0 = 0;
    bit   track = 1'b0;
    int   max_addr = -1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge clka) begin
        if (track && rd_en) begin
            chk("rd_addr_step", int'(rd_addr), cyc - scan_e0);
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("solved", int'(solved), int'(mon_e.s));
                chk("incomplete", int'(incomplete), int'(mon_e.inc));
                chk("conflict", int'(conflict), int'(mon_e.cf));
                chk("err_addr", int'(err_addr), int'(mon_e.ea));
                chk("busy_at_done", int'(busy), 0);
                chk("rd_en_at_done", int'(rd_en), 0);
            end
        end
    end

    task automatic load_valid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                mem[r*9 + c] = 4'(((r*3 + r/3 + c) % 9) + 1);
    endtask

    task automatic run_check(input int lat, input logic s, input logic inc, input logic cf,
                             input int ea, input int repulse_at);
        exp_t e;
        repeat (2) @(negedge clka);
        scan_e0  = cyc + 1;
        max_addr = -1;
        track    = 1'b1;
        check    = 1'b1;
        e.done_cyc = scan_e0 + lat;
        e.s   = s;
        e.inc = inc;
        e.cf  = cf;
        e.ea  = 7'(ea);
        sb_q.push_back(e);
        @(negedge clka);
        check = 1'b0;
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) begin
            check = (repulse_at > 0 && cyc == scan_e0 + repulse_at - 1);
            @(negedge clka);
        end
        check = 1'b0;
        if (sb_q.size() != 0) begin
            chk("done_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        track = 1'b0;
    endtask

    initial begin
        load_valid();
        repeat (3) @(negedge clka);
        chk("reset_outputs", int'({rd_en, rd_addr, busy, done, solved, incomplete, conflict, err_addr}), 0);
        restart_n = 1'b1;
        repeat (4) @(negedge clka);
        chk("idle_no_busy", int'(busy), 0);

        // clean board
        run_check(82, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("max_addr_clean", max_addr, 80);

        // empty cell mid-board
        mem[40] = 4'd0;
        run_check(42, 1'b0, 1'b1, 1'b0, 40, 0);
        chk("max_addr_empty40", max_addr, 41);
        load_valid();

        // box-only duplicate of cell 0's digit
        mem[10] = 4'd1;
        run_check(12, 1'b0, 1'b0, 1'b1, 10, 0);
        load_valid();

        // column-only duplicate of cell 0's digit
        mem[27] = 4'd1;
        run_check(29, 1'b0, 1'b0, 1'b1, 27, 0);
        load_valid();

        // illegal value in the last cell
        mem[80] = 4'd12;
        run_check(82, 1'b0, 1'b0, 1'b1, 80, 0);
        load_valid();

        // empty first cell
        mem[0] = 4'd0;
        run_check(2, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("max_addr_empty0", max_addr, 1);
        load_valid();

        // check re-pulsed mid-scan is ignored
        run_check(82, 1'b1, 1'b0, 1'b0, 0, 20);
        repeat (5) @(negedge clka);
        chk("solved_held", int'(solved), 1);

        // reset mid-scan at E30
        repeat (2) @(negedge clka);
        scan_e0 = cyc + 1;
        track   = 1'b1;
        check   = 1'b1;
        @(negedge clka);
        check = 1'b0;
        while (cyc < scan_e0 + 29) @(negedge clka);
        restart_n = 1'b0;
        @(negedge clka);
        track = 1'b0;
        chk("reset_mid_scan", int'({rd_en, rd_addr, busy, done, solved, incomplete, conflict, err_addr}), 0);
        restart_n = 1'b1;
        repeat (100) @(negedge clka);
        chk("no_busy_after_abort", int'(busy), 0);

        run_check(82, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("max_addr_after_reset", max_addr, 80);

        repeat (3) @(negedge clka);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
